// File: rtl/spi_rdid_top.sv
// M25P16 RDID reader: a debounced button sends 0x9F over SPI mode 0, latches the
// three ID bytes and shows one of them on the LEDs selected by {SW1,SW0}.

module spi_rdid_led_mux (
  input  logic [1:0] sel_i,
  input  logic       blank_i,
  input  logic [7:0] man_i,
  input  logic [7:0] mtype_i,
  input  logic [7:0] cap_i,
  output logic [7:0] led_o
);
  always_comb begin
    led_o = 8'h00;
    if (!blank_i) begin
      case (sel_i)
        2'b00:   led_o = cap_i;
        2'b01:   led_o = mtype_i;
        2'b10:   led_o = man_i;
        default: led_o = 8'hFF;
      endcase
    end
  end
endmodule

module spi_rdid_top #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int SPI_DIV       = 4,
  parameter int CLEAR_CYCLES  = 100000
) (
  input  logic       CCLK,
  input  logic       reset_btn,
  input  logic       get_rdid_btn,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SPIMISO,
  output logic       SPICLK,
  output logic       SPIMOSI,
  output logic       SPISF,
  output logic       LD0, LD1, LD2, LD3, LD4, LD5, LD6, LD7,
  output logic       AMPCS,
  output logic       DACCS,
  output logic       ADCON,
  output logic       SFCE,
  output logic       FPGAIB,
  output logic [1:0] dbg_state_o
);
  localparam int HALF  = SPI_DIV / 2;
  localparam int DIV_W = (SPI_DIV > 2) ? $clog2(SPI_DIV) : 1;
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [7:0] CMD = 8'h9F;

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_e;

  // Reset asserts immediately with the raw button, releases on a CCLK edge.
  logic [1:0] rst_sync_q;
  logic       rst;
  always_ff @(posedge CCLK or posedge reset_btn) begin
    if (reset_btn) rst_sync_q <= 2'b11;
    else           rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  logic [1:0]               btn_sync_q;
  logic                     deb_q, deb_d;
  logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;
  logic                     start_q, start_d;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    start_d   = 1'b0;
    if (btn_sync_q[1] != deb_q) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
      if (&deb_cnt_q) begin
        deb_d     = btn_sync_q[1];
        deb_cnt_d = '0;
        start_d   = btn_sync_q[1];
      end
    end
  end

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic             sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic [23:0]      sh_q, sh_d;
  logic             load;
  logic [7:0]       man_q, mtype_q, cap_q;
  logic             blank_q, blank_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;

  // Clock is high for the first half of each bit period, so MISO is captured at
  // the rise and MOSI moves at the mid-period fall.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    sh_d    = sh_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        cs_n_d = 1'b1;
        div_d  = '0;
        if (start_q) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = CMD[7];
        end
      end
      CS_SETUP: begin
        if (div_q == DIV_W'(HALF - 1)) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          sh_d    = {sh_q[22:0], SPIMISO};
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_W'(HALF - 1)) begin
          sclk_d = 1'b0;
          mosi_d = (bit_q < 5'd7) ? CMD[3'(5'd6 - bit_q)] : 1'b0;
        end
        if (div_q == DIV_W'(SPI_DIV - 1)) begin
          div_d = '0;
          if (bit_q == 5'd31) begin
            state_d = CS_HOLD;
            cs_n_d  = 1'b1;
            load    = 1'b1;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
            sh_d   = {sh_q[22:0], SPIMISO};
          end
        end
      end
      CS_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_W'(SPI_DIV - 1)) begin
          state_d = IDLE;
          div_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blank_d   = blank_q;
    clr_cnt_d = clr_cnt_q;
    if (blank_q) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (load || clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) blank_d = 1'b0;
    end
  end

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      btn_sync_q <= 2'b00;
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      start_q    <= 1'b0;
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sh_q       <= '0;
      man_q      <= 8'h00;
      mtype_q    <= 8'h00;
      cap_q      <= 8'h00;
      blank_q    <= 1'b1;
      clr_cnt_q  <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], get_rdid_btn};
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      start_q    <= start_d;
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      sh_q       <= sh_d;
      if (load) begin
        man_q   <= sh_q[23:16];
        mtype_q <= sh_q[15:8];
        cap_q   <= sh_q[7:0];
      end
      blank_q    <= blank_d;
      clr_cnt_q  <= clr_cnt_d;
    end
  end

  logic [7:0] LED;
  spi_rdid_led_mux ledMux (
    .sel_i   ({SW1, SW0}),
    .blank_i (blank_q),
    .man_i   (man_q),
    .mtype_i (mtype_q),
    .cap_i   (cap_q),
    .led_o   (LED)
  );

  assign {LD7, LD6, LD5, LD4, LD3, LD2, LD1, LD0} = LED;
  assign SPICLK      = sclk_q;
  assign SPIMOSI     = mosi_q;
  assign SPISF       = cs_n_q;
  assign AMPCS       = 1'b1;
  assign DACCS       = 1'b1;
  assign ADCON       = 1'b0;
  assign SFCE        = 1'b1;
  assign FPGAIB      = 1'b1;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_spi_rdid_top.sv
// Bench for spi_rdid_top with an M25P16 RDID responder (ID 0x20/0x20/0x15);
// frame checks run in a monitor fed by an expected-frame queue.

module tb_spi_rdid_top;
  localparam int DB  = 4;
  localparam int DIV = 4;
  localparam int CLR = 3000;

  logic CCLK = 1'b0;
  always #10 CCLK = ~CCLK;

  logic reset_btn = 1'b1;
  logic get_rdid_btn = 1'b0;
  logic SW0 = 1'b1, SW1 = 1'b1;
  logic SPIMISO = 1'b0;
  logic SPICLK, SPIMOSI, SPISF;
  logic LD0, LD1, LD2, LD3, LD4, LD5, LD6, LD7;
  logic AMPCS, DACCS, ADCON, SFCE, FPGAIB;
  logic [1:0] dbg_state;
  logic [7:0] led;
  assign led = {LD7, LD6, LD5, LD4, LD3, LD2, LD1, LD0};

  spi_rdid_top #(.DEBOUNCE_BITS(DB), .SPI_DIV(DIV), .CLEAR_CYCLES(CLR)) dut (
    .CCLK(CCLK), .reset_btn(reset_btn), .get_rdid_btn(get_rdid_btn),
    .SW0(SW0), .SW1(SW1), .SPIMISO(SPIMISO),
    .SPICLK(SPICLK), .SPIMOSI(SPIMOSI), .SPISF(SPISF),
    .LD0(LD0), .LD1(LD1), .LD2(LD2), .LD3(LD3),
    .LD4(LD4), .LD5(LD5), .LD6(LD6), .LD7(LD7),
    .AMPCS(AMPCS), .DACCS(DACCS), .ADCON(ADCON), .SFCE(SFCE), .FPGAIB(FPGAIB),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic abort = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash responder
  logic [23:0] flash_id = 24'h202015;
  int          rise_cnt = 0;
  logic [7:0]  cmd_cap  = 8'h00;
  int          frames   = 0;

  always @(negedge SPISF) begin
    rise_cnt = 0;
    cmd_cap  = 8'h00;
  end

  always @(posedge SPICLK) begin
    if (!SPISF) begin
      if (rise_cnt < 8) cmd_cap = {cmd_cap[6:0], SPIMOSI};
      rise_cnt++;
    end
  end

  always @(negedge SPICLK or posedge SPISF) begin
    if (SPISF) SPIMISO = 1'b0;
    else if (rise_cnt >= 8 && rise_cnt < 32) SPIMISO = flash_id[31 - rise_cnt];
    else SPIMISO = 1'b0;
  end

  // Monitor: every completed frame is scored against the head of exp_q.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge SPISF);
      if (!abort) begin
        frames++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got frame %0d, expected none", frames);
        end else begin
          e = exp_q.pop_front();
          check("frame_cmd", {24'h0, cmd_cap}, {24'h0, e[15:8]});
          check("frame_sclk_pulses", rise_cnt, {24'h0, e[7:0]});
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CCLK);
  endtask

  task automatic press(input int bounces);
    for (int i = 0; i < bounces; i++) begin
      get_rdid_btn = 1'b1; #40;
      get_rdid_btn = 1'b0; #40;
    end
    get_rdid_btn = 1'b1;
  endtask

  task automatic release_btn();
    for (int i = 0; i < 3; i++) begin
      get_rdid_btn = 1'b0; #40;
      get_rdid_btn = 1'b1; #40;
    end
    get_rdid_btn = 1'b0;
    wait_cycles((1 << DB) + 30);
  endtask

  task automatic wait_frame(input string name);
    int f0;
    int n;
    f0 = frames;
    n  = 0;
    while (frames == f0 && n < 300) begin
      @(posedge CCLK);
      n++;
    end
    check(name, (frames != f0) ? 32'd1 : 32'd0, 32'd1);
    wait_cycles(5);
  endtask

  task automatic led_at(input logic [1:0] sw, input string name, input logic [7:0] exp);
    @(negedge CCLK);
    {SW1, SW0} = sw;
    #1;
    check(name, {24'h0, led}, {24'h0, exp});
  endtask

  initial begin
    int f0;
    int n;
    // 1: bouncing reset, blanking with SW=11
    for (int i = 0; i < 4; i++) begin
      #80 reset_btn = 1'b0;
      #80 reset_btn = 1'b1;
    end
    #2000;
    check("spisf_in_reset", {31'h0, SPISF}, 32'd1);
    reset_btn = 1'b0;
    wait_cycles(5);
    @(negedge CCLK);
    check("spisf_after_reset", {31'h0, SPISF}, 32'd1);
    check("spiclk_after_reset", {31'h0, SPICLK}, 32'd0);
    check("mosi_after_reset", {31'h0, SPIMOSI}, 32'd0);
    check("state_after_reset", {30'h0, dbg_state}, 32'd0);
    check("bus_deselects", {27'h0, AMPCS, DACCS, ADCON, SFCE, FPGAIB}, 32'b11011);
    check("led_blank_sw11", {24'h0, led}, 32'h00);
    abort = 1'b0;

    // 2: bouncy press gives one 0x9F frame
    exp_q.push_back({8'h9F, 8'd32});
    press(10);
    wait_frame("frame1_done");
    release_btn();
    led_at(2'b00, "led_cap", 8'h15);

    // 3: switch sweep
    led_at(2'b01, "led_type", 8'h20);
    led_at(2'b10, "led_man", 8'h20);
    led_at(2'b11, "led_ff", 8'hFF);

    // 4: glitch shorter than the debounce window, then a real second press
    f0 = frames;
    get_rdid_btn = 1'b1;
    wait_cycles((1 << DB) / 2);
    get_rdid_btn = 1'b0;
    wait_cycles(200);
    check("short_glitch_no_frame", frames, f0);
    exp_q.push_back({8'h9F, 8'd32});
    press(4);
    wait_frame("frame2_done");
    release_btn();
    led_at(2'b00, "led_cap_again", 8'h15);
    led_at(2'b10, "led_man_again", 8'h20);

    // 5: long reset with SW=11, blanking then timeout
    @(negedge CCLK);
    {SW1, SW0} = 2'b11;
    abort = 1'b1;
    reset_btn = 1'b1;
    wait_cycles(40);
    reset_btn = 1'b0;
    wait_cycles(10);
    abort = 1'b0;
    led_at(2'b11, "led_blank_after_reset", 8'h00);
    wait_cycles(CLR - 200);
    led_at(2'b11, "led_still_blank", 8'h00);
    wait_cycles(300);
    led_at(2'b11, "led_ff_after_clear", 8'hFF);
    led_at(2'b00, "led_cap_cleared", 8'h00);

    // 6: reset in the middle of SHIFT
    press(2);
    n = 0;
    while (!(SPISF == 1'b0 && rise_cnt >= 12) && n < 400) begin
      @(posedge CCLK);
      n++;
    end
    check("reached_mid_shift", (n < 400) ? 32'd1 : 32'd0, 32'd1);
    @(negedge CCLK);
    abort = 1'b1;
    reset_btn = 1'b1;
    #1;
    check("spisf_async_abort", {31'h0, SPISF}, 32'd1);
    get_rdid_btn = 1'b0;
    wait_cycles(20);
    reset_btn = 1'b0;
    wait_cycles(10);
    abort = 1'b0;
    led_at(2'b00, "led_after_abort", 8'h00);
    exp_q.push_back({8'h9F, 8'd32});
    press(3);
    wait_frame("frame3_done");
    release_btn();
    led_at(2'b00, "led_cap_after_abort", 8'h15);
    led_at(2'b01, "led_type_after_abort", 8'h20);

    check("pending_frames", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
